pwm_fade_sequencer: RTL and testbench

Autonomous controller that drives the register bus of the two-channel PWM peripheral to produce duty-cycle ramps (fades) without CPU involvement. After one start command it programs the divisor, period and initial duty cycle, and enables the selected channel. It then steps the duty-cycle register toward a target at a fixed dwell interval. In loop mode it ping-pongs between the two end points until stopped. It sits between the SoC configuration registers and the PWM register port, as the only writer on that port while busy.

---
 rtl/pwm_seq_pkg.sv | 33 +++
 rtl/pwm_seq_timer.sv | 31 +++
 rtl/pwm_fade_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM fade sequencer: FSM states, PWM register
// map offsets, channel base addresses and control words.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DIV,
    S_WR_PER,
    S_WR_DC0,
    S_WR_CTRL,
    S_HOLD,
    S_WR_DC,
    S_WR_STOP
  } seq_state_t;

  localparam logic [7:0] OFS_CTRL = 8'h00;
  localparam logic [7:0] OFS_DIV  = 8'h04;
  localparam logic [7:0] OFS_PER  = 8'h08;
  localparam logic [7:0] OFS_DC   = 8'h0C;

  // Index 0 is channel 1 (base 0x00), index 1 is channel 2 (base 0x10).
  localparam logic [1:0][7:0] CH_BASE = {8'h10, 8'h00};

  // Start bit 2 plus output-enable bit 4.
  localparam logic [31:0] CTRL_RUN = 32'h0000_0014;
  localparam logic [31:0] CTRL_OFF = 32'h0000_0000;

  // Full bus address of a register within the selected channel.
  function automatic logic [7:0] reg_addr(input logic chan, input logic [7:0] ofs);
    return CH_BASE[chan] + ofs;
  endfunction

endpackage

// File: rtl/pwm_seq_timer.sv
// Loadable dwell down-counter. A load sets the count; the count then runs
// down to zero and 'expired' is high during the last counted cycle.
module pwm_seq_timer #(
  parameter int HOLD_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              clear,
  input  logic [HOLD_W-1:0] load_value,
  output logic              expired
);

  logic [HOLD_W-1:0] count;

  // Load wins over clear; otherwise count down and park at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - HOLD_W'(1);
    end
  end

  assign expired = (count == HOLD_W'(1));

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Autonomous duty-cycle fader. After a start pulse it programs divisor,
// period and initial duty of one PWM channel, enables it, then steps the
// duty register toward the target once per dwell interval, optionally
// ping-ponging between the two end points until stopped.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int HOLD_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              chan_i,
  input  logic              loop_i,
  input  logic [15:0]       divisor_i,
  input  logic [15:0]       period_i,
  input  logic [15:0]       dc_start_i,
  input  logic [15:0]       dc_end_i,
  input  logic [15:0]       step_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              we_o,
  output logic              re_o,
  output logic [7:0]        addr_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        be_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       dc_o
);

  seq_state_t        state;
  logic              chan_q;
  logic              loop_q;
  logic [15:0]       period_q;
  logic [15:0]       start_q;
  logic [15:0]       end_q;
  logic [15:0]       step_q;
  logic [HOLD_W-1:0] hold_q;
  logic              dir_up;
  logic [15:0]       cur_dc;

  logic [16:0]       sum;
  logic [16:0]       diff;
  logic [15:0]       next_dc;
  logic              at_end;
  logic              stop_hit;
  logic              tmr_load;
  logic              tmr_clear;
  logic [HOLD_W-1:0] tmr_value;
  logic              tmr_expired;

  // The sequencer never reads the PWM block.
  assign re_o = 1'b0;

  assign at_end    = (cur_dc == end_q);
  assign stop_hit  = stop_i && (state != S_IDLE) && (state != S_WR_STOP);
  assign tmr_value = (hold_q == '0) ? HOLD_W'(1) : hold_q;
  assign tmr_load  = !stop_hit &&
                     (((state == S_WR_CTRL) && !at_end) ||
                      ((state == S_WR_DC) && (!at_end || loop_q)));
  assign tmr_clear = stop_hit;

  // Next duty value: one step toward the target in 17-bit arithmetic,
  // clamped to the target on overshoot, wrap or a zero step.
  always_comb begin
    sum     = {1'b0, cur_dc} + {1'b0, step_q};
    diff    = {1'b0, cur_dc} - {1'b0, step_q};
    next_dc = end_q;
    if (step_q != '0) begin
      if (dir_up) begin
        if (sum < {1'b0, end_q}) next_dc = sum[15:0];
      end else begin
        if (!diff[16] && (diff[15:0] > end_q)) next_dc = diff[15:0];
      end
    end
  end

  pwm_seq_timer #(
    .HOLD_W(HOLD_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (tmr_load),
    .clear      (tmr_clear),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  // Sequencer FSM with registered bus outputs; a stop overrides every busy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      be_o     <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      dc_o     <= '0;
      chan_q   <= 1'b0;
      loop_q   <= 1'b0;
      period_q <= '0;
      start_q  <= '0;
      end_q    <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      dir_up   <= 1'b0;
      cur_dc   <= '0;
    end else begin
      we_o    <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      be_o    <= '0;
      done_o  <= 1'b0;
      if (stop_hit) begin
        state   <= S_WR_STOP;
        we_o    <= 1'b1;
        be_o    <= 4'hF;
        addr_o  <= reg_addr(chan_q, OFS_CTRL);
        wdata_o <= CTRL_OFF;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              chan_q   <= chan_i;
              loop_q   <= loop_i;
              period_q <= period_i;
              start_q  <= dc_start_i;
              end_q    <= dc_end_i;
              step_q   <= step_i;
              hold_q   <= hold_i;
              dir_up   <= (dc_start_i < dc_end_i);
              cur_dc   <= dc_start_i;
              state    <= S_WR_DIV;
              busy_o   <= 1'b1;
              we_o     <= 1'b1;
              be_o     <= 4'hF;
              addr_o   <= reg_addr(chan_i, OFS_DIV);
              wdata_o  <= {16'h0000, divisor_i};
            end
          end
          S_WR_DIV: begin
            state   <= S_WR_PER;
            we_o    <= 1'b1;
            be_o    <= 4'hF;
            addr_o  <= reg_addr(chan_q, OFS_PER);
            wdata_o <= {16'h0000, period_q};
          end
          S_WR_PER: begin
            state   <= S_WR_DC0;
            we_o    <= 1'b1;
            be_o    <= 4'hF;
            addr_o  <= reg_addr(chan_q, OFS_DC);
            wdata_o <= {16'h0000, cur_dc};
            dc_o    <= cur_dc;
          end
          S_WR_DC0: begin
            state   <= S_WR_CTRL;
            we_o    <= 1'b1;
            be_o    <= 4'hF;
            addr_o  <= reg_addr(chan_q, OFS_CTRL);
            wdata_o <= CTRL_RUN;
          end
          S_WR_CTRL: begin
            if (at_end) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (tmr_expired) begin
              state   <= S_WR_DC;
              we_o    <= 1'b1;
              be_o    <= 4'hF;
              addr_o  <= reg_addr(chan_q, OFS_DC);
              wdata_o <= {16'h0000, next_dc};
              dc_o    <= next_dc;
              cur_dc  <= next_dc;
            end
          end
          S_WR_DC: begin
            if (at_end && !loop_q) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state <= S_HOLD;
              if (at_end) begin
                start_q <= end_q;
                end_q   <= start_q;
                dir_up  <= !dir_up;
              end
            end
          end
          S_WR_STOP: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer. A bus monitor logs every write
// with its cycle number; a behavioural ramp model builds the expected log.
module tb_pwm_fade_sequencer;

  localparam int HOLD_W = 24;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              chan_i = 1'b0;
  logic              loop_i = 1'b0;
  logic [15:0]       divisor_i = '0;
  logic [15:0]       period_i = '0;
  logic [15:0]       dc_start_i = '0;
  logic [15:0]       dc_end_i = '0;
  logic [15:0]       step_i = '0;
  logic [HOLD_W-1:0] hold_i = '0;
  logic              we_o;
  logic              re_o;
  logic [7:0]        addr_o;
  logic [31:0]       wdata_o;
  logic [3:0]        be_o;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       dc_o;

  always #5 clk_i = ~clk_i;

  pwm_fade_sequencer #(.HOLD_W(HOLD_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .chan_i     (chan_i),
    .loop_i     (loop_i),
    .divisor_i  (divisor_i),
    .period_i   (period_i),
    .dc_start_i (dc_start_i),
    .dc_end_i   (dc_end_i),
    .step_i     (step_i),
    .hold_i     (hold_i),
    .we_o       (we_o),
    .re_o       (re_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .be_o       (be_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .dc_o       (dc_o)
  );

  typedef struct {
    bit chan;
    bit loop;
    int div;
    int per;
    int dcs;
    int dce;
    int step;
    int hold;
  } cfg_t;

  // Packed write record: {cycle[15:0], addr[7:0], data[31:0]}.
  typedef logic [55:0] wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  done_q[$];
  int  exp_done;
  int  exp_dc;
  int  checks = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  int  busy_cnt = 0;
  int  bus_err = 0;

  function automatic wr_t mk(input int lbl, input int addr, input int data);
    return {lbl[15:0], addr[7:0], data[31:0]};
  endfunction

  // Rising-edge counter used to label bus cycles.
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  // Bus monitor: logs writes, strobe discipline, busy cycles and done pulses.
  always @(negedge clk_i) begin
    if (we_o) begin
      obs_q.push_back(mk(edge_cnt + 1, int'(addr_o), int'(wdata_o)));
      if (be_o !== 4'hF) bus_err++;
    end else if (be_o !== 4'h0) begin
      bus_err++;
    end
    if (re_o !== 1'b0) bus_err++;
    if (busy_o === 1'b1) busy_cnt++;
    if (done_o === 1'b1) done_q.push_back(edge_cnt + 1);
  end

  // Reference: setup writes, then one step toward the target every hold+1 cycles.
  task automatic build_model(input cfg_t c, input int t, input int max_dc);
    int base, h, dc, tgt, other, n, lbl, cnt;
    exp_q.delete();
    base = c.chan ? 16 : 0;
    exp_q.push_back(mk(t + 1, base + 4, c.div));
    exp_q.push_back(mk(t + 2, base + 8, c.per));
    exp_q.push_back(mk(t + 3, base + 12, c.dcs));
    exp_q.push_back(mk(t + 4, base, 32'h14));
    exp_dc = c.dcs;
    exp_done = -1;
    if (c.dcs == c.dce) begin
      exp_done = t + 5;
      return;
    end
    h = (c.hold == 0) ? 1 : c.hold;
    dc = c.dcs;
    tgt = c.dce;
    other = c.dcs;
    lbl = t + 4;
    cnt = 0;
    while (cnt < max_dc) begin
      lbl += h + 1;
      if (dc < tgt) begin
        n = dc + c.step;
        if (c.step == 0 || n >= tgt) n = tgt;
      end else begin
        n = dc - c.step;
        if (c.step == 0 || n <= tgt) n = tgt;
      end
      exp_q.push_back(mk(lbl, base + 12, n));
      dc = n;
      exp_dc = n;
      cnt++;
      if (dc == tgt) begin
        if (!c.loop) begin
          exp_done = lbl + 1;
          return;
        end
        n = tgt;
        tgt = other;
        other = n;
      end
    end
  endtask

  task automatic start_seq(input cfg_t c, output int t);
    @(posedge clk_i);
    #2;
    obs_q.delete();
    done_q.delete();
    busy_cnt = 0;
    bus_err = 0;
    chan_i = c.chan;
    loop_i = c.loop;
    divisor_i = c.div[15:0];
    period_i = c.per[15:0];
    dc_start_i = c.dcs[15:0];
    dc_end_i = c.dce[15:0];
    step_i = c.step[15:0];
    hold_i = c.hold[HOLD_W-1:0];
    start_i = 1'b1;
    t = edge_cnt + 1;
    @(posedge clk_i);
    #2;
    start_i = 1'b0;
    chan_i = 1'($urandom);
    loop_i = 1'($urandom);
    divisor_i = 16'($urandom);
    period_i = 16'($urandom);
    dc_start_i = 16'($urandom);
    dc_end_i = 16'($urandom);
    step_i = 16'($urandom);
    hold_i = HOLD_W'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_q.size() == 0; i++) @(posedge clk_i);
    repeat (4) @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    outs = {we_o, re_o, addr_o, wdata_o, be_o, busy_o, done_o, dc_o};
    checks++;
    if (outs !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    outs = {we_o, re_o, addr_o, wdata_o, be_o, busy_o, done_o, dc_o};
    checks++;
    if (outs !== 64'h0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected 0", outs);
    end
  endtask

  task automatic test_fixed_ramps();
    cfg_t tbl[5];
    int   upd[5];
    int   t;
    wr_t  got;
    tbl[0] = '{0, 0, 2, 100, 10, 40, 10, 5};
    tbl[1] = '{1, 0, 7, 200, 50, 5, 20, 2};
    tbl[2] = '{0, 0, 3, 300, 10, 200, 0, 4};
    tbl[3] = '{1, 0, 4, 50, 25, 25, 5, 3};
    tbl[4] = '{0, 0, 1, 65535, 65520, 65535, 32, 2};
    upd = '{3, 3, 1, 0, 1};
    for (int k = 0; k < 5; k++) begin
      start_seq(tbl[k], t);
      build_model(tbl[k], t, 1000);
      wait_done(exp_done - t + 20);
      checks++;
      if (obs_q.size() != 4 + upd[k]) begin
        failures++;
        $display("FAIL fixed%0d_write_count: got %0d expected %0d", k, obs_q.size(), 4 + upd[k]);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < obs_q.size()) ? obs_q[i] : '1;
        checks++;
        if (got !== exp_q[i]) begin
          failures++;
          $display("FAIL fixed%0d_write%0d: got %h expected %h", k, i, got, exp_q[i]);
        end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != exp_done) begin
        failures++;
        $display("FAIL fixed%0d_done: got %0d pulses first at %0d expected one at %0d", k, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
      end
      checks++;
      if (busy_cnt != exp_done - t - 1) begin
        failures++;
        $display("FAIL fixed%0d_busy_cycles: got %0d expected %0d", k, busy_cnt, exp_done - t - 1);
      end
      checks++;
      if (bus_err != 0 || dc_o !== exp_dc[15:0]) begin
        failures++;
        $display("FAIL fixed%0d_strobe_dc: got errs=%0d dc=%0d expected errs=0 dc=%0d", k, bus_err, dc_o, exp_dc);
      end
    end
  endtask

  task automatic test_random_ramps();
    cfg_t c;
    int   t;
    wr_t  got;
    for (int k = 0; k < 8; k++) begin
      c.chan = 1'($urandom);
      c.loop = 1'b0;
      c.div = int'($urandom_range(0, 65535));
      c.per = int'($urandom_range(0, 65535));
      c.dcs = int'($urandom_range(0, 300));
      c.dce = int'($urandom_range(0, 300));
      c.step = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 80));
      c.hold = int'($urandom_range(0, 4));
      start_seq(c, t);
      build_model(c, t, 1000);
      wait_done(exp_done - t + 20);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_write_count: got %0d expected %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < obs_q.size()) ? obs_q[i] : '1;
        checks++;
        if (got !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_write%0d: got %h expected %h", k, i, got, exp_q[i]);
        end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != exp_done || busy_cnt != exp_done - t - 1) begin
        failures++;
        $display("FAIL rand%0d_done_busy: got done=%0d busy=%0d expected done=%0d busy=%0d", k, (done_q.size() > 0) ? done_q[0] : -1, busy_cnt, exp_done, exp_done - t - 1);
      end
      checks++;
      if (bus_err != 0 || dc_o !== exp_dc[15:0]) begin
        failures++;
        $display("FAIL rand%0d_strobe_dc: got errs=%0d dc=%0d expected errs=0 dc=%0d", k, bus_err, dc_o, exp_dc);
      end
    end
  endtask

  task automatic test_loop_stop();
    cfg_t c;
    int   t, s, guard, base, lastdc, ndc;
    wr_t  keep[$];
    wr_t  got;
    int   pat[8];
    pat = '{0, 1, 2, 3, 2, 1, 0, 1};
    c = '{1'($urandom), 1, 9, 99, 0, 3, 1, 1};
    base = c.chan ? 16 : 0;
    start_seq(c, t);
    s = t + 5 + 2 * int'($urandom_range(7, 10));
    guard = 0;
    while (edge_cnt < s - 1 && guard < 500) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    #1;
    stop_i = 1'b1;
    @(posedge clk_i);
    #2;
    stop_i = 1'b0;
    wait_done(20);
    build_model(c, t, 100);
    keep.delete();
    lastdc = 0;
    foreach (exp_q[i]) begin
      if (int'(exp_q[i][55:40]) <= s) begin
        keep.push_back(exp_q[i]);
        if (exp_q[i][39:32] == 8'(base + 12)) lastdc = int'(exp_q[i][15:0]);
      end
    end
    keep.push_back(mk(s + 1, base, 0));
    exp_done = s + 2;
    checks++;
    if (obs_q.size() != keep.size()) begin
      failures++;
      $display("FAIL loop_write_count: got %0d expected %0d", obs_q.size(), keep.size());
    end
    for (int i = 0; i < keep.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++;
      if (got !== keep[i]) begin
        failures++;
        $display("FAIL loop_write%0d: got %h expected %h", i, got, keep[i]);
      end
    end
    ndc = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][39:32] == 8'(base + 12) && ndc < 8) begin
        checks++;
        if (obs_q[i][31:0] !== 32'(pat[ndc])) begin
          failures++;
          $display("FAIL loop_pattern%0d: got %0d expected %0d", ndc, obs_q[i][31:0], pat[ndc]);
        end
        ndc++;
      end
    end
    checks++;
    if (ndc != 8) begin
      failures++;
      $display("FAIL loop_pattern_len: got %0d expected 8", ndc);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != exp_done || busy_cnt != exp_done - t - 1) begin
      failures++;
      $display("FAIL loop_stop_done_busy: got done=%0d busy=%0d expected done=%0d busy=%0d", (done_q.size() > 0) ? done_q[0] : -1, busy_cnt, exp_done, exp_done - t - 1);
    end
    checks++;
    if (dc_o !== lastdc[15:0]) begin
      failures++;
      $display("FAIL loop_dc_hold: got %0d expected %0d", dc_o, lastdc);
    end
  endtask

  task automatic test_back_to_back();
    cfg_t c;
    int   t;
    wr_t  got;
    c = '{0, 0, 11, 222, 0, 50, 10, 3};
    start_seq(c, t);
    build_model(c, t, 1000);
    repeat (8) @(posedge clk_i);
    #2;
    chan_i = 1'b1;
    dc_start_i = 16'd500;
    dc_end_i = 16'd100;
    step_i = 16'd7;
    start_i = 1'b1;
    @(posedge clk_i);
    #2;
    start_i = 1'b0;
    wait_done(exp_done - t + 20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL busy_start_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_start_write%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != exp_done) begin
      failures++;
      $display("FAIL busy_start_done: got %0d expected %0d", (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    end
  endtask

  task automatic test_idle_pulses();
    @(posedge clk_i);
    #2;
    obs_q.delete();
    done_q.delete();
    busy_cnt = 0;
    start_i = 1'b1;
    stop_i = 1'b1;
    @(posedge clk_i);
    #2;
    start_i = 1'b0;
    @(posedge clk_i);
    #2;
    stop_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #2;
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 0 || busy_cnt != 0) begin
      failures++;
      $display("FAIL idle_pulses: got writes=%0d done=%0d busy=%0d expected all 0", obs_q.size(), done_q.size(), busy_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    cfg_t        c;
    int          t, guard;
    logic [63:0] outs;
    wr_t         got;
    c = '{1, 0, 5, 60, 5, 100, 10, 20};
    start_seq(c, t);
    guard = 0;
    while (edge_cnt < t + 8 && guard < 100) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    #1;
    checks++;
    if (busy_o !== 1'b1 || dc_o !== 16'd5) begin
      failures++;
      $display("FAIL pre_reset_state: got busy=%b dc=%0d expected busy=1 dc=5", busy_o, dc_o);
    end
    rst_i = 1'b1;
    #1;
    outs = {we_o, re_o, addr_o, wdata_o, be_o, busy_o, done_o, dc_o};
    checks++;
    if (outs !== 64'h0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h expected 0", outs);
    end
    obs_q.delete();
    done_q.delete();
    #10;
    rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #2;
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_quiet: got writes=%0d done=%0d expected 0", obs_q.size(), done_q.size());
    end
    c = '{1'($urandom), 0, int'($urandom_range(0, 65535)), 77, int'($urandom_range(0, 40)), int'($urandom_range(60, 120)), int'($urandom_range(5, 30)), 2};
    start_seq(c, t);
    build_model(c, t, 1000);
    wait_done(exp_done - t + 20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL restart_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL restart_write%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != exp_done) begin
      failures++;
      $display("FAIL restart_done: got %0d expected %0d", (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    end
  endtask

  initial begin
    $display("[TB] pwm_fade_sequencer bench starting");
    test_reset();
    test_fixed_ramps();
    test_random_ramps();
    test_loop_stop();
    test_back_to_back();
    test_idle_pulses();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
